ko_banner_sequencer: RTL and testbench

- Sequences the KO text overlay on the 96x64 OLED when a round ends.
- On a KO event it freezes gameplay, blinks the KO banner, holds it solid, then pulses round-over to the game FSM.
- Sits between the game renderer and the OLED driver. It multiplexes the game pixel colour with the colour from the KO text bitmap ROM; both are indexed by the same pixel_index.

---
 rtl/ko_banner_sequencer.sv | 140 ++++++++++++++
 tb/tb_ko_banner_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ko_banner_sequencer.sv
// ============================================================================
// Module  : ko_banner_sequencer
// Purpose : KO banner overlay sequencer (freeze, blink, hold, round-over pulse)
//           with a registered game/KO pixel mux. Optional macro: KO_DIM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ko_banner_sequencer #(
  parameter int FREEZE_FRAMES = 15,
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_COUNT   = 3,
  parameter int HOLD_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        ko_trigger,
  input  logic [15:0] game_colour,
  input  logic [15:0] ko_colour,
  output logic [15:0] oled_colour,
  output logic        overlay_on,
  output logic        freeze,
  output logic        busy,
  output logic        round_over
);

  localparam logic [7:0] C_FREEZE_LAST = 8'(FREEZE_FRAMES - 1);
  localparam logic [7:0] C_BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] C_HOLD_LAST   = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0] C_CYCLE_LAST  = 4'(BLINK_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FREEZE    = 3'd1,
    BLINK_ON  = 3'd2,
    BLINK_OFF = 3'd3,
    HOLD      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [3:0]  r_blink;
  logic [3:0]  w_blink_next;
  logic        r_overlay;
  logic        r_busy;
  logic        r_round_over;
  logic [15:0] r_oled;
  logic [15:0] w_pix;

  // Timed states only advance on a frame tick so overlay edges land on frame boundaries.
  always_comb begin
    w_next       = r_state;
    w_blink_next = r_blink;
    case (r_state)
      IDLE: begin
        if (ko_trigger) w_next = FREEZE;
      end
      FREEZE: begin
        if (frame_tick && r_cnt == C_FREEZE_LAST) begin
          w_next       = BLINK_ON;
          w_blink_next = 4'd0;
        end
      end
      BLINK_ON: begin
        if (frame_tick && r_cnt == C_BLINK_LAST) w_next = BLINK_OFF;
      end
      BLINK_OFF: begin
        if (frame_tick && r_cnt == C_BLINK_LAST) begin
          if (r_blink == C_CYCLE_LAST) begin
            w_next = HOLD;
          end else begin
            w_next       = BLINK_ON;
            w_blink_next = r_blink + 4'd1;
          end
        end
      end
      HOLD: begin
        if (frame_tick && r_cnt == C_HOLD_LAST) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_pix = game_colour;
    if (r_overlay) begin
      if (ko_colour != 16'h0000) begin
        w_pix = ko_colour;
      end else begin
`ifdef KO_DIM_EN
        w_pix = {1'b0, game_colour[15:12], 1'b0, game_colour[10:6], 1'b0, game_colour[4:1]};
`else
        w_pix = game_colour;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_blink      <= 4'd0;
      r_overlay    <= 1'b0;
      r_busy       <= 1'b0;
      r_round_over <= 1'b0;
      r_oled       <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_blink <= w_blink_next;
      if (w_next != r_state) begin
        r_cnt <= 8'd0;
      end else if (frame_tick && r_state != IDLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
      // Status flags decode the next state so they line up with the state itself.
      r_overlay    <= (w_next == BLINK_ON) || (w_next == HOLD);
      r_busy       <= (w_next != IDLE);
      r_round_over <= (w_next == DONE);
      r_oled       <= w_pix;
    end
  end

  assign oled_colour = r_oled;
  assign overlay_on  = r_overlay;
  assign freeze      = r_busy;
  assign busy        = r_busy;
  assign round_over  = r_round_over;

endmodule

`default_nettype wire

// File: tb/tb_ko_banner_sequencer.sv
// ============================================================================
// Module  : tb_ko_banner_sequencer
// Purpose : Directed self-checking bench for ko_banner_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ko_banner_sequencer;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        ko_trigger;
  logic [15:0] game_colour;
  logic [15:0] ko_colour;
  logic [15:0] oled_colour;
  logic        overlay_on;
  logic        freeze;
  logic        busy;
  logic        round_over;

  logic        d_tick;
  logic        d_trig;
  logic [15:0] d_oled;
  logic        d_overlay;
  logic        d_freeze;
  logic        d_busy;
  logic        d_round_over;

  int n_checks;
  int n_fail;
  int ro_cnt;

  ko_banner_sequencer #(
    .FREEZE_FRAMES(2), .BLINK_FRAMES(2), .BLINK_COUNT(2), .HOLD_FRAMES(3)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .ko_trigger(ko_trigger),
    .game_colour(game_colour), .ko_colour(ko_colour), .oled_colour(oled_colour),
    .overlay_on(overlay_on), .freeze(freeze), .busy(busy), .round_over(round_over)
  );

  ko_banner_sequencer dut_def (
    .clk(clk), .reset(reset), .frame_tick(d_tick), .ko_trigger(d_trig),
    .game_colour(game_colour), .ko_colour(ko_colour), .oled_colour(d_oled),
    .overlay_on(d_overlay), .freeze(d_freeze), .busy(d_busy), .round_over(d_round_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (round_over) ro_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  function automatic logic exp_overlay(input int n);
    return (n == 2 || n == 3 || n == 6 || n == 7 || n == 10 || n == 11 || n == 12);
  endfunction

  function automatic logic [15:0] dim(input logic [15:0] c);
    return {c[15:11] >> 1, c[10:5] >> 1, c[4:0] >> 1};
  endfunction

  // mode 0: plain run with pixel checks, 1: extra trigger in BLINK_OFF, 2: trigger coincident with tick
  task automatic run_seq(input int mode);
    int ro_start;
    ro_start = ro_cnt;
    ko_trigger = 1'b1;
    if (mode == 2) frame_tick = 1'b1;
    @(negedge clk);
    ko_trigger = 1'b0;
    frame_tick = 1'b0;
    check("busy_after_trig", {31'd0, busy}, 32'd1);
    check("freeze_after_trig", {31'd0, freeze}, 32'd1);
    check("overlay_after_trig", {31'd0, overlay_on}, 32'd0);
    for (int n = 1; n <= 13; n++) begin
      tick();
      if (n < 13) begin
        check($sformatf("overlay_t%0d_m%0d", n, mode), {31'd0, overlay_on}, {31'd0, exp_overlay(n)});
        check($sformatf("ro_low_t%0d", n), {31'd0, round_over}, 32'd0);
      end else begin
        check("round_over_pulse", {31'd0, round_over}, 32'd1);
        check("overlay_done", {31'd0, overlay_on}, 32'd0);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("round_over_end", {31'd0, round_over}, 32'd0);
        check("freeze_end", {31'd0, freeze}, 32'd0);
        check("busy_end", {31'd0, busy}, 32'd0);
      end
      if (mode == 1 && n == 4) begin
        ko_trigger = 1'b1;
        @(negedge clk);
        ko_trigger = 1'b0;
        check("overlay_ignored_trig", {31'd0, overlay_on}, 32'd0);
        check("busy_ignored_trig", {31'd0, busy}, 32'd1);
        idle_clks(8);
      end else if (mode == 0 && n == 10) begin
        ko_colour   = 16'hFFFF;
        game_colour = 16'h1234;
        @(negedge clk);
        check("hold_text_pix", {16'd0, oled_colour}, 32'h0000FFFF);
        ko_colour = 16'h0000;
        @(negedge clk);
`ifdef KO_DIM_EN
        check("hold_dim_pix", {16'd0, oled_colour}, {16'd0, dim(16'h1234)});
`else
        check("hold_game_pix", {16'd0, oled_colour}, 32'h00001234);
`endif
        idle_clks(7);
      end else if (mode == 0 && n == 4) begin
        ko_colour   = 16'hFFFF;
        game_colour = 16'hA5A5;
        @(negedge clk);
        check("blink_off_pix", {16'd0, oled_colour}, 32'h0000A5A5);
        idle_clks(8);
      end else begin
        idle_clks(9);
      end
    end
    check("ro_single_pulse", ro_cnt - ro_start, 32'd1);
  endtask

  initial begin
    int ro_before;
    n_checks = 0;
    n_fail = 0;
    ro_cnt = 0;
    reset = 1'b1;
    frame_tick = 1'b0;
    ko_trigger = 1'b0;
    d_tick = 1'b0;
    d_trig = 1'b0;
    game_colour = 16'h0000;
    ko_colour = 16'h0000;
    idle_clks(3);
    check("rst_oled", {16'd0, oled_colour}, 32'd0);
    check("rst_flags", {28'd0, overlay_on, freeze, busy, round_over}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    game_colour = 16'h1234;
    ko_colour   = 16'hFFFF;
    @(negedge clk);
    check("idle_pix", {16'd0, oled_colour}, 32'h00001234);

    run_seq(0);
    idle_clks(5);
    run_seq(1);
    idle_clks(5);
    run_seq(2);
    idle_clks(5);

    // Reset during HOLD
    ro_before = ro_cnt;
    ko_trigger = 1'b1;
    @(negedge clk);
    ko_trigger = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      tick();
      idle_clks(2);
    end
    check("pre_rst_hold", {31'd0, overlay_on}, 32'd1);
    ko_colour = 16'hFFFF;
    @(negedge clk);
    check("pre_rst_pix", {16'd0, oled_colour}, 32'h0000FFFF);
    #2 reset = 1'b1;
    #1;
    check("midrst_oled", {16'd0, oled_colour}, 32'd0);
    check("midrst_flags", {28'd0, overlay_on, freeze, busy, round_over}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_flags2", {28'd0, overlay_on, freeze, busy, round_over}, 32'd0);
    idle_clks(20);
    check("midrst_no_ro", ro_cnt - ro_before, 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);
    run_seq(0);

    // Default parameters: 15 + 2*8*3 + 60 = 123 ticks
    d_trig = 1'b1;
    @(negedge clk);
    d_trig = 1'b0;
    for (int n = 1; n <= 123; n++) begin
      d_tick = 1'b1;
      @(negedge clk);
      d_tick = 1'b0;
      if (n == 15) check("def_blink_on", {31'd0, d_overlay}, 32'd1);
      if (n == 122) check("def_ro_early", {30'd0, d_round_over, d_busy}, 32'd1);
      if (n == 123) check("def_ro_123", {31'd0, d_round_over}, 32'd1);
      idle_clks(2);
    end
    check("def_idle_after", {30'd0, d_busy, d_round_over}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
